// File: rtl/aer_input_rr.sv
`default_nettype none
// ============================================================================
//  Module   : aer_input_rr
//  Brief    : AER transmitter front-end. Latches Up/Down spikes per channel,
//             arbitrates round-robin and sends {ch, down} over 4-phase req/ack.
//  Revision : 1.0  initial release
// ============================================================================
module aer_input_rr #(
    parameter  int NUM_CH      = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int ACK_TIMEOUT = 255,
    localparam int ADDR_W      = (2 * NUM_CH > 2) ? $clog2(2 * NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     ch_up,
    input  logic [NUM_CH-1:0]     ch_down,
    input  logic                  ack,
    output logic                  req,
    output logic [ADDR_W-1:0]     addr,
    output logic [2*NUM_CH-1:0]   pending,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  busy
);

    localparam int c_NUM_SRC = 2 * NUM_CH;
    localparam int c_CNT_W   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_ACK_LOW = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_req;
    logic                   r_busy;
    logic                   r_overflow;
    logic                   r_timeout;
    logic [ADDR_W-1:0]      r_addr;
    logic [ADDR_W-1:0]      r_ptr;
    logic [c_NUM_SRC-1:0]   r_pending;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [SYNC_STAGES-1:0] r_ack_sync;

    logic [c_NUM_SRC-1:0]   w_spike;
    logic [c_NUM_SRC-1:0]   w_clr;
    logic [c_NUM_SRC-1:0]   w_pend_nxt;
    logic [ADDR_W-1:0]      w_grant;
    logic [ADDR_W-1:0]      w_ptr_nxt;
    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic                   w_any;
    logic                   w_ack_s;
    logic                   w_do_grant;
    logic                   w_drop;
    logic                   w_to_hit;

    // Source i = 2*ch + down: even indices are Up, odd are Down.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_src
        assign w_spike[2*c]     = ch_up[c];
        assign w_spike[2*c + 1] = ch_down[c];
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // First pending source at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        w_any   = 1'b0;
        w_grant = '0;
        idx     = 0;
        for (int i = 0; i < c_NUM_SRC; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= c_NUM_SRC) begin
                idx = idx - c_NUM_SRC;
            end
            if (!w_any && r_pending[idx]) begin
                w_any   = 1'b1;
                w_grant = ADDR_W'(idx);
            end
        end
    end

    assign w_do_grant = (r_state == S_IDLE) && w_any && !w_ack_s;
    assign w_clr      = w_do_grant ? (c_NUM_SRC'(1) << w_grant) : '0;
    // A spike on the source being granted re-queues it without counting as a drop.
    assign w_pend_nxt = (r_pending & ~w_clr) | w_spike;
    assign w_drop     = |(w_spike & r_pending & ~w_clr);
    assign w_ptr_nxt  = (w_grant == ADDR_W'(c_NUM_SRC - 1)) ? '0 : w_grant + 1'b1;

    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_to_hit   = (ACK_TIMEOUT != 0) && (w_cnt_inc == c_CNT_W'(ACK_TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_addr     <= '0;
            r_ptr      <= '0;
            r_pending  <= '0;
            r_cnt      <= '0;
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
            r_pending  <= w_pend_nxt;
            r_overflow <= w_drop;
            r_timeout  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_do_grant) begin
                        r_addr  <= w_grant;
                        r_ptr   <= w_ptr_nxt;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_ACK_LOW;
                    end else if (w_to_hit) begin
                        r_req     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (ACK_TIMEOUT != 0) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_ACK_LOW: begin
                    if (!w_ack_s) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_to_hit) begin
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (ACK_TIMEOUT != 0) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req      = r_req;
    assign addr     = r_addr;
    assign pending  = r_pending;
    assign overflow = r_overflow;
    assign timeout  = r_timeout;
    assign busy     = r_busy;

endmodule
`default_nettype wire
